// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: ceiling log2 and pointer width derivation.
// Pointers are {wrap, index}; the index is wide enough for any DEPTH >= 2.
package fifo_pkg;

   function automatic int clogb2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int idx_width(input int depth);
      return (clogb2(depth) < 1) ? 1 : clogb2(depth);
   endfunction

   function automatic int ptr_width(input int depth);
      return idx_width(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_replay_fifo_sdp_ram.sv
// Simple dual-port RAM with a 1-cycle registered read.
// Ports: clk; wen/waddr/wdata write port; ren/raddr/rdata read port.
module sdp_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 784,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  ren,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
      if (ren) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sync_replay_fifo.sv
// Replay FIFO: FWFT read stream whose delivered words stay resident until
// committed by mark; rewind replays from the last mark point.
// Ports: clk, rst (sync, active-high), clear (sync flush);
//   s_data/s_valid/s_ready write stream; m_data/m_valid/m_ready read stream;
//   mark (commit delivered), rewind (replay), empty, full.
// Optional (macro SYNC_REPLAY_FIFO_LEVEL_EN): level, avail, almost_full and
//   parameter ALMOST_FULL_GAP.
module sync_replay_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 784
`ifdef SYNC_REPLAY_FIFO_LEVEL_EN
   , parameter int ALMOST_FULL_GAP = 4
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   input  logic                  mark,
   input  logic                  rewind,
   output logic                  empty,
   output logic                  full
`ifdef SYNC_REPLAY_FIFO_LEVEL_EN
   , output logic [clogb2(DEPTH):0] level
   , output logic [clogb2(DEPTH):0] avail
   , output logic                   almost_full
`endif
);

   localparam int AW = idx_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   // Index wraps DEPTH-1 -> 0 and toggles the wrap bit; no carry is
   // possible into the wrap bit because index+1 <= DEPTH-1 < 2**AW.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p[AW-1:0] == LAST) begin
         return {~p[PW-1], {AW{1'b0}}};
      end
      return p + PW'(1);
   endfunction

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] dlv_ptr;
   logic [PW-1:0] mrk_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_nxt;
   logic [PW-1:0] dlv_nxt;
   logic [PW-1:0] mrk_nxt;
   logic [PW-1:0] rd_nxt;

   logic                  wen;
   logic                  ren;
   logic                  pop;
   logic                  push;
   logic                  flush;
   logic                  ram_vld;
   logic [DATA_WIDTH-1:0] ram_q;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] skid;
   logic [1:0]            cnt;
   logic [1:0]            occ;
   logic                  room;

   // Retained (delivered but unmarked) words occupy space.
   assign full    = (wr_ptr[AW-1:0] == mrk_ptr[AW-1:0]) &&
                    (wr_ptr[PW-1] != mrk_ptr[PW-1]);
   assign empty   = (wr_ptr == dlv_ptr);
   assign s_ready = !full;
   assign m_valid = (cnt != 2'd0);
   assign m_data  = head;

   assign flush = clear || rewind;
   assign wen   = s_valid && !full && !clear;
   assign pop   = m_valid && m_ready;
   assign push  = ram_vld && !flush;

   // Words held in the skid plus the read landing this cycle; a new read
   // is issued only if it is guaranteed a skid slot after this cycle's pop.
   assign occ  = cnt + {1'b0, ram_vld};
   assign room = (occ <= (2'd1 + {1'b0, pop}));
   assign ren  = (rd_ptr != wr_ptr) && room && !flush;

   always_comb begin
      wr_nxt  = wr_ptr;
      dlv_nxt = dlv_ptr;
      mrk_nxt = mrk_ptr;
      rd_nxt  = rd_ptr;
      if (wen) begin
         wr_nxt = next_ptr(wr_ptr);
      end
      if (ren) begin
         rd_nxt = next_ptr(rd_ptr);
      end
      if (pop) begin
         dlv_nxt = next_ptr(dlv_ptr);
      end
      // A handshake coinciding with rewind is dropped and replayed.
      if (rewind) begin
         dlv_nxt = mrk_ptr;
         rd_nxt  = mrk_ptr;
      end else if (mark) begin
         mrk_nxt = dlv_nxt;
      end
      if (clear) begin
         wr_nxt  = '0;
         dlv_nxt = '0;
         mrk_nxt = '0;
         rd_nxt  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         dlv_ptr <= '0;
         mrk_ptr <= '0;
         rd_ptr  <= '0;
      end else begin
         wr_ptr  <= wr_nxt;
         dlv_ptr <= dlv_nxt;
         mrk_ptr <= mrk_nxt;
         rd_ptr  <= rd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cnt     <= 2'd0;
         ram_vld <= 1'b0;
      end else begin
         cnt     <= cnt + {1'b0, push} - {1'b0, pop};
         ram_vld <= ren;
      end
   end

   // head is the presented word; skid catches a landing read while the
   // consumer stalls. A push never meets cnt == 2 (see room).
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         skid <= '0;
      end else if (push) begin
         if ((cnt == 2'd0) || ((cnt == 2'd1) && pop)) begin
            head <= ram_q;
         end else begin
            skid <= ram_q;
         end
      end else if (!flush && pop && (cnt == 2'd2)) begin
         head <= skid;
      end
   end

   sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .clk   (clk),
      .wen   (wen),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (s_data),
      .ren   (ren),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (ram_q)
   );

`ifdef SYNC_REPLAY_FIFO_LEVEL_EN
   localparam int LW    = AW + 1;
   localparam int AF_TH = (DEPTH > ALMOST_FULL_GAP) ?
                          (DEPTH - ALMOST_FULL_GAP) : 0;

   function automatic logic [LW-1:0] dist(input logic [PW-1:0] a,
                                          input logic [PW-1:0] b);
      logic [LW-1:0] ai;
      logic [LW-1:0] bi;
      ai = {1'b0, a[AW-1:0]};
      bi = {1'b0, b[AW-1:0]};
      if (a[PW-1] == b[PW-1]) begin
         return ai - bi;
      end
      return ai + LW'(DEPTH) - bi;
   endfunction

   // Registered from next-state pointers so they track the live pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         level       <= '0;
         avail       <= '0;
         almost_full <= 1'b0;
      end else begin
         level       <= dist(wr_nxt, mrk_nxt);
         avail       <= dist(wr_nxt, dlv_nxt);
         almost_full <= (dist(wr_nxt, mrk_nxt) >= LW'(AF_TH));
      end
   end
`endif

endmodule

// File: doc/sync_replay_fifo.md
SYNC_REPLAY_FIFO -- requirements
Module: sync_replay_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 784, entry count; any value 2..65536, not restricted to a power of two.
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port clear  in  1  synchronous flush of all contents and pointers.
REQ-006 SHALL have ports s_data in DATA_WIDTH, s_valid in 1, s_ready out 1: write stream.
REQ-007 SHALL have ports m_data out DATA_WIDTH, m_valid out 1, m_ready in 1: read stream, first-word-fall-through.
REQ-008 SHALL have port mark  in  1  pulse: commit all delivered words, freeing their space.
REQ-009 SHALL have port rewind  in  1  pulse: replay from last mark point.
REQ-010 SHALL have ports empty out 1 (no undelivered words) and full out 1 (no free entries).

Function
REQ-011 SHALL accept a write on s_valid && s_ready; s_ready = !full; full counts retained (delivered, unmarked) words as occupied.
REQ-012 SHALL keep three pointers: wr_ptr, dlv_ptr (next word to deliver), mrk_ptr (oldest retained word); each wraps DEPTH-1 -> 0 with a wrap bit for full/empty disambiguation.
REQ-013 SHALL deliver a word on m_valid && m_ready; m_data SHALL be stable while m_valid && !m_ready.
REQ-014 SHALL present the first word into an empty FIFO with m_valid high 2 cycles after its accepting edge (1 RAM read cycle + 1 output register).
REQ-015 SHALL sustain 1 word/cycle on both sides simultaneously, using a 2-entry output skid so that m_ready deassertion loses no in-flight RAM read.
REQ-016 SHALL on mark set mrk_ptr to dlv_ptr after this cycle's delivery (dlv_ptr+1 if a handshake occurs the same cycle); full deasserts the next cycle if space freed.
REQ-017 SHALL on rewind set dlv_ptr and RAM read pointer to mrk_ptr, flush skid and in-flight read, drive m_valid low the next cycle, and re-present the mark-point word 2 cycles after the rewind edge.
REQ-018 SHALL discard a handshake coinciding with rewind (that word is replayed).
REQ-019 SHALL give rewind priority over mark when both assert; mark SHALL then be ignored.
REQ-020 SHALL treat rewind with dlv_ptr == mrk_ptr as a no-op except for the pipeline flush.
REQ-021 SHALL accept a write coincident with mark/rewind normally.
REQ-022 SHALL give clear priority over all other inputs; the cycle after clear it is empty, not full, m_valid low.
REQ-023 SHALL not write when full; s_valid while full has no effect.

Reset
REQ-024 SHALL on rst set all pointers 0, m_valid 0, s_ready 1, empty 1, full 0, m_data 0; RAM contents undefined.
REQ-025 SHALL abort any in-flight read on rst asserted mid-operation; no output change is produced by it after reset.

Configuration
REQ-026 SHALL, with SYNC_REPLAY_FIFO_LEVEL_EN defined, add outputs level (clogb2(DEPTH)+1 bits, wr_ptr - mrk_ptr), avail (same width, wr_ptr - dlv_ptr), and almost_full (level >= DEPTH - ALMOST_FULL_GAP, parameter default 4), all registered, reset 0.
REQ-027 SHALL, without SYNC_REPLAY_FIFO_LEVEL_EN, omit those ports and parameter and their logic entirely.

Structure
REQ-028 SHALL take the clogb2 function and pointer-width derivation from the shared package fifo_pkg.
REQ-029 SHALL instantiate storage as one sub-module sdp_ram (simple dual port, 1-cycle registered read, write port and read port enables).

Verification
REQ-030 SHALL verify fill: DEPTH=5, write 0x11..0x15 with m_ready=0 -> full=1 after 5th write, s_ready=0, 6th write ignored.
REQ-031 SHALL verify latency/throughput: write 0xA0 into empty -> m_valid high at accept+2; continuous 100-word stream with m_ready=1 -> 1 word/cycle, in order.
REQ-032 SHALL verify replay: write 1..4, mark, read 1,2, rewind -> m_valid low next cycle, then 1,2,3,4 re-delivered.
REQ-033 SHALL verify commit: DEPTH=4, write 4, read 2, full stays 1; mark -> full=0 next cycle, two more writes accepted.
REQ-034 SHALL verify simultaneity: mark+rewind same cycle -> mark ignored; handshake+rewind same cycle -> that word replayed.
REQ-035 SHALL verify clear/rst mid-stream with m_ready toggling -> empty=1, m_valid=0 next cycle, no stale word emerges afterward.
